alu_sequencer: RTL

- Operand/result sequencer sitting directly around the 8-bit combinational `alu`:
  - accepts byte operand pairs from the datapath controller over a valid/ready handshake;
  - drives the ALU's `a`, `b`, `carryIn` and `en_b` from registers;
  - captures `out` and `carryOut` into a result register presented downstream over valid/ready.
- Chains carry across consecutive bytes, so multi-byte adds run LSB-first without controller involvement.

---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/alu_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand/result sequencer.
// Width defaults, FSM state encoding and result-register reset values.
package alu_seq_pkg;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_HOLD
    } state_e;

    localparam logic RES_CARRY_RST = 1'b0;
    localparam logic RES_LAST_RST  = 1'b0;
    localparam logic RES_ZERO_RST  = 1'b0;
    localparam logic CHAIN_RST     = 1'b0;
    localparam logic ZACC_RST      = 1'b1;

endpackage

// File: rtl/alu_sequencer.sv
// Registers byte operands for the external ALU, captures its result and
// chains carry / zero state across the bytes of a multi-byte word.
module alu_sequencer #(
    parameter int WIDTH = alu_seq_pkg::WIDTH,
    parameter int IDX_W = alu_seq_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_en_b,
    input  logic             op_first,
    input  logic             op_cin,
    input  logic             op_last,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_carry_in,
    output logic             alu_en_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_last,
    output logic             res_zero,
    output logic [IDX_W-1:0] res_idx
);

    import alu_seq_pkg::*;

    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             en_b_q, en_b_d;
    logic             cin_q, cin_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             chain_q, chain_d;
    logic             zacc_q, zacc_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rcarry_q, rcarry_d;
    logic             rlast_q, rlast_d;
    logic             rzero_q, rzero_d;
    logic [IDX_W-1:0] ridx_q, ridx_d;
    logic             zero_now;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        en_b_d   = en_b_q;
        cin_d    = cin_q;
        first_d  = first_q;
        last_d   = last_q;
        idx_d    = idx_q;
        chain_d  = chain_q;
        zacc_d   = zacc_q;
        rdata_d  = rdata_q;
        rcarry_d = rcarry_q;
        rlast_d  = rlast_q;
        rzero_d  = rzero_q;
        ridx_d   = ridx_q;
        zero_now = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    en_b_d  = op_en_b;
                    cin_d   = op_first ? op_cin : chain_q;
                    first_d = op_first;
                    last_d  = op_last;
                    idx_d   = op_first ? '0 : ridx_q + IDX_ONE;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // a word's zero flag covers every byte captured so far
                zero_now = (alu_out == '0) && (first_q || zacc_q);
                rdata_d  = alu_out;
                rcarry_d = alu_carry_out;
                rlast_d  = last_q;
                rzero_d  = zero_now;
                ridx_d   = idx_q;
                chain_d  = last_q ? CHAIN_RST : alu_carry_out;
                zacc_d   = last_q ? ZACC_RST : zero_now;
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            en_b_q   <= 1'b0;
            cin_q    <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            idx_q    <= '0;
            chain_q  <= CHAIN_RST;
            zacc_q   <= ZACC_RST;
            rdata_q  <= '0;
            rcarry_q <= RES_CARRY_RST;
            rlast_q  <= RES_LAST_RST;
            rzero_q  <= RES_ZERO_RST;
            ridx_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            en_b_q   <= en_b_d;
            cin_q    <= cin_d;
            first_q  <= first_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
            chain_q  <= chain_d;
            zacc_q   <= zacc_d;
            rdata_q  <= rdata_d;
            rcarry_q <= rcarry_d;
            rlast_q  <= rlast_d;
            rzero_q  <= rzero_d;
            ridx_q   <= ridx_d;
        end
    end

    assign op_ready     = (state_q == S_IDLE) && !rst;
    assign res_valid    = (state_q == S_HOLD);
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_carry_in = cin_q;
    assign alu_en_b     = en_b_q;
    assign res_data     = rdata_q;
    assign res_carry    = rcarry_q;
    assign res_last     = rlast_q;
    assign res_zero     = rzero_q;
    assign res_idx      = ridx_q;

endmodule
